// File: rtl/lut_bank_pipe.sv
// CH independent K-input lookup tables fed from a double-buffered, serially
// loaded configuration store, evaluated through a two-stage valid/ready pipeline.
module lut_bank_pipe #(
    parameter int K  = 4,
    parameter int CH = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            cfg_start,
    input  logic            cfg_valid,
    input  logic            cfg_bit,
    output logic            cfg_ready,
    output logic            cfg_done,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [CH*K-1:0] in_sel,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [CH-1:0]   out
);
    localparam int TBL = 1 << K;
    localparam int N   = CH * TBL;
    localparam int CW  = $clog2(N + 1);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic {
        IDLE,
        LOAD
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [N-1:0]  shadow_q, shadow_d;
    logic [N-1:0]  active_q, active_d;
    logic          done_q, done_d;

    logic            s1_valid_q, s1_valid_d;
    logic [CH*K-1:0] s1_sel_q, s1_sel_d;
    logic            out_valid_q, out_valid_d;
    logic [CH-1:0]   out_q, out_d;
    logic [CH-1:0]   lut_val;
    logic            s1_adv, s2_adv;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        shadow_d  = shadow_q;
        active_d  = active_q;
        done_d    = 1'b0;
        cfg_ready = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (cfg_start) begin
                    state_d = LOAD;
                    cnt_d   = '0;
                end
            end
            LOAD: begin
                cfg_ready = 1'b1;
                // A restart wins over a bit presented in the same cycle.
                if (cfg_start) begin
                    cnt_d = '0;
                end else if (cfg_valid) begin
                    shadow_d = {shadow_q[N-2:0], cfg_bit};
                    cnt_d    = cnt_q + CW'(1);
                    if (cnt_q == LAST) begin
                        active_d = shadow_d;
                        done_d   = 1'b1;
                        state_d  = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            shadow_q <= '0;
            active_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            shadow_q <= shadow_d;
            active_q <= active_d;
            done_q   <= done_d;
        end
    end

    assign s2_adv   = !out_valid_q || out_ready;
    assign s1_adv   = !s1_valid_q || s2_adv;
    assign in_ready = s1_adv;

    always_comb begin
        logic [TBL-1:0] tbl;
        logic [K-1:0]   sel;
        tbl     = '0;
        sel     = '0;
        lut_val = '0;
        for (int unsigned c = 0; c < CH; c++) begin
            tbl        = active_q[c*TBL +: TBL];
            sel        = s1_sel_q[c*K +: K];
            lut_val[c] = tbl[sel];
        end
    end

    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_sel_d    = s1_sel_q;
        out_valid_d = out_valid_q;
        out_d       = out_q;
        if (s2_adv) begin
            out_valid_d = s1_valid_q;
            if (s1_valid_q) out_d = lut_val;
        end
        if (s1_adv) begin
            s1_valid_d = in_valid;
            if (in_valid) s1_sel_d = in_sel;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_sel_q    <= '0;
            out_valid_q <= 1'b0;
            out_q       <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_sel_q    <= s1_sel_d;
            out_valid_q <= out_valid_d;
            out_q       <= out_d;
        end
    end

    assign cfg_done  = done_q;
    assign out_valid = out_valid_q;
    assign out       = out_q;
endmodule

// File: tb/tb_lut_bank_pipe.sv
// Randomised scoreboard bench for lut_bank_pipe: a negedge monitor tracks the
// configuration protocol and table history, and checks every emitted result.
module tb_lut_bank_pipe;
    localparam int K  = 4;
    localparam int CH = 4;
    localparam int T  = 1 << K;
    localparam int N  = CH * T;
    localparam int SW = CH * K;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cfg_start = 1'b0, cfg_valid = 1'b0, cfg_bit = 1'b0;
    logic          cfg_ready, cfg_done;
    logic          in_valid = 1'b0, in_ready;
    logic [SW-1:0] in_sel = '0;
    logic          out_valid, out_ready = 1'b1;
    logic [CH-1:0] out;

    lut_bank_pipe #(.K(K), .CH(CH)) dut (
        .clk(clk), .rst(rst),
        .cfg_start(cfg_start), .cfg_valid(cfg_valid), .cfg_bit(cfg_bit),
        .cfg_ready(cfg_ready), .cfg_done(cfg_done),
        .in_valid(in_valid), .in_ready(in_ready), .in_sel(in_sel),
        .out_valid(out_valid), .out_ready(out_ready), .out(out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [SW-1:0] sel;
        bit            fixed;
        logic [CH-1:0] exp;
    } item_t;

    item_t         sbq[$];
    int            compared = 0, mismatched = 0;
    int            cyc = 0;
    bit            fx = 0;
    logic [CH-1:0] fxv = '0;
    int            done_cnt = 0;
    bit            saw_inready_low = 0;

    // Reference state: load protocol, table history and commit edge.
    bit            m_load = 0;
    int            m_cnt = 0;
    logic [N-1:0]  m_shadow = '0, tbl_cur = '0, tbl_prev = '0;
    int            commit_edge = -1;
    bit            s2adv_prev = 0, rst_prev = 1;
    logic [CH-1:0] held = '0;

    function automatic logic [CH-1:0] ref_eval(input logic [N-1:0] tbl, input logic [SW-1:0] sel);
        logic [CH-1:0] r;
        logic [SW-1:0] s;
        int idx;
        r = '0;
        for (int c = 0; c < CH; c++) begin
            s    = sel >> (c * K);
            idx  = c * T + int'(s[K-1:0]);
            r[c] = tbl[idx];
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial forever begin
        item_t it;
        logic [CH-1:0] e;
        @(negedge clk);
        if (cfg_done) done_cnt++;
        if (!in_ready) saw_inready_low = 1;
        if (rst_prev) begin
            check("reset out_valid", 32'(out_valid), 32'(0));
            check("reset out", 32'(out), 32'(0));
            check("reset cfg_ready", 32'(cfg_ready), 32'(0));
            check("reset cfg_done", 32'(cfg_done), 32'(0));
        end else begin
            check("cfg_ready", 32'(cfg_ready), 32'(m_load));
            check("cfg_done", 32'(cfg_done), 32'(cyc == commit_edge));
            if (out_valid && s2adv_prev) begin
                if (sbq.size() == 0) begin
                    check("unexpected output", 32'(1), 32'(0));
                end else begin
                    it = sbq.pop_front();
                    e  = it.fixed ? it.exp
                                  : ref_eval((cyc > commit_edge) ? tbl_cur : tbl_prev, it.sel);
                    check("lookup", 32'(out), 32'(e));
                end
                held = out;
            end else if (out_valid) begin
                check("stall hold", 32'(out), 32'(held));
            end
        end
        // Events for the coming edge.
        rst_prev   = rst;
        s2adv_prev = !out_valid || out_ready;
        if (rst) begin
            m_load = 0; m_cnt = 0; m_shadow = '0; tbl_cur = '0; tbl_prev = '0;
            sbq.delete();
        end else begin
            if (in_valid && in_ready) sbq.push_back('{sel: in_sel, fixed: fx, exp: fxv});
            if (m_load) begin
                if (cfg_start) m_cnt = 0;
                else if (cfg_valid) begin
                    m_shadow = {m_shadow[N-2:0], cfg_bit};
                    m_cnt++;
                    if (m_cnt == N) begin
                        tbl_prev    = tbl_cur;
                        tbl_cur     = m_shadow;
                        commit_edge = cyc + 1;
                        m_load      = 0;
                    end
                end
            end else if (cfg_start) begin
                m_load = 1;
                m_cnt  = 0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_sel(input logic [SW-1:0] sel, input bit fixed, input logic [CH-1:0] exp);
        bit r;
        int n;
        in_valid = 1'b1; in_sel = sel; fx = fixed; fxv = exp;
        n = 0;
        do begin
            @(negedge clk);
            r = in_ready;
            tick();
            n++;
        end while (!r && n < 200);
        if (!r) check("in_ready timeout", 32'(0), 32'(1));
        in_valid = 1'b0; fx = 0;
    endtask

    task automatic stream(input int n);
        repeat (n) send_sel(SW'($urandom), 0, '0);
    endtask

    task automatic pulse_start();
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
    endtask

    task automatic send_cfg(input logic [63:0] v, input int nbits);
        for (int i = 63; i > 63 - nbits; i--) begin
            if ($urandom_range(3) == 0) begin
                cfg_valid = 1'b0;
                tick();
            end
            cfg_valid = 1'b1;
            cfg_bit   = v[i];
            tick();
        end
        cfg_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((sbq.size() != 0 || out_valid) && n < 200) begin
            tick();
            n++;
        end
        check("drain", 32'(sbq.size()), 32'(0));
    endtask

    initial begin
        logic [63:0] pat;
        repeat (3) tick();
        rst = 1'b0;

        // Empty tables evaluate to zero; no configuration activity.
        repeat (4) send_sel(16'hFFFF, 1, 4'b0000);
        drain();

        pat = 64'hAAAA_6996_FFFE_8000;
        pulse_start();
        send_cfg(pat, 64);
        repeat (3) tick();
        send_sel(16'hFFFF, 1, 4'b1011);
        send_sel(16'h0000, 1, 4'b0000);
        send_sel(16'h1111, 1, 4'b1110);
        stream(12);
        drain();

        // Backpressure: stall for 3 cycles at first out_valid.
        saw_inready_low = 0;
        fork
            stream(6);
            begin
                int n = 0;
                while (!out_valid && n < 100) begin
                    tick();
                    n++;
                end
                out_ready = 1'b0;
                repeat (3) tick();
                out_ready = 1'b1;
            end
        join
        drain();
        check("in_ready dropped", 32'(saw_inready_low), 32'(1));

        // Hot reload of all-zero tables under random backpressure.
        fork
            stream(60);
            begin
                pulse_start();
                send_cfg(64'h0, 64);
            end
            begin
                repeat (90) begin
                    out_ready = ($urandom_range(3) != 0);
                    tick();
                end
                out_ready = 1'b1;
            end
        join
        out_ready = 1'b1;
        drain();
        repeat (4) send_sel(SW'($urandom), 1, 4'b0000);
        drain();

        // Abort: partial load, restart with a simultaneous bit, then full load.
        done_cnt = 0;
        pat = {$urandom, $urandom};
        pulse_start();
        send_cfg({$urandom, $urandom}, 20);
        cfg_start = 1'b1; cfg_valid = 1'b1; cfg_bit = 1'b1;
        tick();
        cfg_start = 1'b0; cfg_valid = 1'b0;
        send_cfg(pat, 64);
        repeat (3) tick();
        check("abort done count", 32'(done_cnt), 32'(1));
        stream(20);
        drain();
        send_sel(16'hFFFF, 1, {pat[63], pat[47], pat[31], pat[15]});
        send_sel(16'h0000, 1, {pat[48], pat[32], pat[16], pat[0]});
        drain();

        // Reset in the middle of a load with the pipeline occupied.
        pulse_start();
        send_cfg({$urandom, $urandom}, 30);
        out_ready = 1'b0;
        stream(2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        out_ready = 1'b1;
        check("post-reset out_valid", 32'(out_valid), 32'(0));
        check("post-reset cfg_ready", 32'(cfg_ready), 32'(0));
        cfg_valid = 1'b1; cfg_bit = 1'b1;
        repeat (3) tick();
        cfg_valid = 1'b0;
        repeat (10) send_sel(SW'($urandom), 1, 4'b0000);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/lut_bank_pipe.md
Name: lut_bank_pipe

Overview:
Parametrised successor to the fixed-size mux trees. It holds CH independent K-input lookup tables, each a 2^K:1 select tree whose data inputs come from a configuration store. The store is loaded serially through a handshake and is double-buffered, so the bank keeps evaluating with the old tables while a new set loads. Evaluation is a 2-stage valid/ready pipeline. It is the configurable universal-gate core used by the user-project logic.

Parameters:
K, 4, select bits per LUT (legal 1..6); table size 2^K bits per channel.
CH, 4, number of independent LUT channels (legal 1..16).

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
cfg_start  in  1  one-cycle pulse; start or restart a configuration load
cfg_valid  in  1  cfg_bit is valid this cycle
cfg_bit  in  1  serial configuration bit
cfg_ready  out  1  high while in LOAD; a bit is accepted when cfg_valid && cfg_ready
cfg_done  out  1  one-cycle pulse when the new tables are committed
in_valid  in  1  select vector valid
in_ready  out  1  pipeline can accept in_sel this cycle
in_sel  in  CH*K  channel c select = in_sel[c*K +: K]
out_valid  out  1  out holds a result
out_ready  in  1  downstream accepts out this cycle
out  out  CH  out[c] = LUT c evaluated on its select

Behaviour:
- Reset (synchronous, rst=1 at a clock edge):
  - FSM goes to IDLE; bit counter = 0.
  - Active table and shadow shift register are cleared to all-zero.
  - Both pipeline stage valids are cleared; out = 0; out_valid = 0.
  - cfg_ready = 0; cfg_done = 0.
  - Reset overrides all other inputs in that cycle.
- Config FSM has two states:
  - IDLE: cfg_ready = 0. cfg_start moves to LOAD and clears the counter.
  - LOAD: cfg_ready = 1.
    - Each accepted bit shifts the shadow register left: shadow = {shadow[N-2:0], cfg_bit}, with N = CH*2^K. The counter increments.
    - On the accept that brings the counter to N: at that edge, active <= the fully shifted value (including that bit). cfg_done is 1 in the following cycle only. FSM returns to IDLE.
    - cfg_start in LOAD discards partial data: counter = 0, stay in LOAD, active table untouched. A simultaneous cfg_valid bit is dropped.
    - cfg_valid while in IDLE is ignored.
- Table layout: table_c = active[c*2^K +: 2^K], and out[c] = table_c[sel_c] with natural binary indexing. Because bits shift in MSB first, the first bit sent ends up at active[N-1] (channel CH-1, entry 2^K-1).
- Pipeline:
  - Stage 1 registers in_sel and valid.
  - Stage 2 registers out, computed combinationally from the stage-1 select and the active table at the S1->S2 transfer edge.
  - Latency in_valid accept -> out_valid is 2 cycles with no stall. Throughput is 1 per cycle.
  - Advance rules:
    - s2_adv = !out_valid || out_ready.
    - s1_adv = !s1_valid || s2_adv.
    - in_ready = s1_adv (combinational).
  - Stalled stages hold their contents; no duplication or loss.
- Commit timing: a lookup performed at the same edge as the commit uses the old table. Lookups at all later edges use the new table. Items already in stage 2 are not re-evaluated.
- Configuration loading and evaluation are fully independent. Evaluation never stalls because of configuration.

Test Plan:
- Reset then stream in_sel=16'hFFFF: out_valid asserts 2 cycles after accept with out=4'b0000. cfg_ready stays 0 and cfg_done never pulses.
- Load 64 bits MSB-first of 64'hAAAA_6996_FFFE_8000 (ch3=AAAA, ch2=6996, ch1=FFFE, ch0=8000): cfg_done pulses exactly 1 cycle after the 64th accept. Then:
  - in_sel=16'hFFFF -> out=4'b1011.
  - in_sel=16'h0000 -> out=4'b0000.
  - in_sel=16'h1111 -> out=4'b1110.
- Backpressure: stream 6 selects with out_ready=0 for 3 cycles starting on the first out_valid. in_ready drops once both stages are full. All 6 results arrive in order with correct values.
- Hot reload: stream continuously while loading 64'h0 over the previous tables. Results whose lookup edge is at or before the commit edge use old values; later results are 4'b0000.
- Abort: cfg_start, send 20 bits, cfg_start again, then 64 bits of a new pattern. Exactly one cfg_done pulse occurs, 64 accepts after the second start, and the tables match the new pattern only.
- Reset after 30 bits of a load: FSM returns to IDLE, cfg_ready=0, the active table is all-zero, and the pipeline is empty (out_valid=0).
